// File: rtl/median_select_ctrl.sv
// median_select_ctrl: sequences fill_buffers through value-domain bisection
// passes over one pixel window until the rank-k (median) element is isolated.
//
// Handshakes:
//   start/busy        : start is taken only in IDLE with a legal window size.
//   replay_req        : single-cycle pulse in ISSUE asking the source to replay.
//   fill_done         : one-cycle strobe from fill_buffers; results sampled then.
//   median_valid/ready: valid rises on entry to DONE and stays high, with median
//                       held, until a cycle where valid && ready; the transfer
//                       completes on that edge.
module median_select_ctrl #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BUFF_SIZE_BIT-1:0] win_size,
  output logic                     busy,
  output logic [7:0]               pivot,
  output logic                     fb_sending,
  output logic                     replay_req,
  input  logic                     fill_done,
  input  logic [BUFF_SIZE_BIT-1:0] lower_size,
  input  logic [BUFF_SIZE_BIT-1:0] equal_size,
  input  logic [7:0]               max_lower,
  input  logic [7:0]               min_larger,
  output logic [7:0]               median,
  output logic                     median_valid,
  input  logic                     median_ready,
  output logic [3:0]               pass_count,
  output logic [2:0]               state_dbg
);

  localparam int BW = BUFF_SIZE_BIT;
  localparam logic [BW-1:0] MAX_N = BW'(BUFF_SIZE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_FILL   = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] n_q, k_q, l_q, e_q;
  logic [7:0]    lo_q, hi_q, pivot_q, median_q, maxl_q, minl_q;
  logic [3:0]    pass_q;

  logic          win_ok;
  logic [BW:0]   sum_le;
  logic          k_lt_l, k_lt_le, collapse;
  logic [7:0]    new_lo, new_hi, mid;
  logic [8:0]    mid_sum;

  assign win_ok = (win_size != '0) && (win_size <= MAX_N);

  // Bisection step: narrow [lo,hi] from the sampled partition of this pass
  always_comb begin
    sum_le  = {1'b0, l_q} + {1'b0, e_q};
    k_lt_l  = (k_q < l_q);
    k_lt_le = ({1'b0, k_q} < sum_le);
    new_lo  = lo_q;
    new_hi  = hi_q;
    if (k_lt_l)        new_hi = maxl_q;
    else if (!k_lt_le) new_lo = minl_q;
    collapse = (new_lo == new_hi);
    mid_sum  = {1'b0, new_lo} + {1'b0, new_hi};
    mid      = mid_sum[8:1];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && win_ok) state_d = S_LOAD;
      S_LOAD:   state_d = S_ISSUE;
      S_ISSUE:  state_d = S_FILL;
      S_FILL:   if (fill_done) state_d = S_DECIDE;
      S_DECIDE: begin
        if (!k_lt_l && k_lt_le) state_d = S_DONE;
        else if (collapse)      state_d = S_DONE;
        else                    state_d = S_ISSUE;
      end
      S_DONE:   if (median_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers: window size, rank, search bounds, pivot, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      k_q      <= '0;
      l_q      <= '0;
      e_q      <= '0;
      lo_q     <= 8'd0;
      hi_q     <= 8'd255;
      pivot_q  <= 8'd0;
      median_q <= 8'd0;
      maxl_q   <= 8'd0;
      minl_q   <= 8'd0;
      pass_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: if (start && win_ok) n_q <= win_size;
        S_LOAD: begin
          k_q     <= (n_q - BW'(1)) >> 1;
          lo_q    <= 8'd0;
          hi_q    <= 8'd255;
          pivot_q <= 8'd127;
          pass_q  <= 4'd0;
        end
        S_ISSUE: if (pass_q != 4'd15) pass_q <= pass_q + 4'd1;
        // fill_buffers clears its results on the next edge, so capture now
        S_FILL: if (fill_done) begin
          l_q    <= lower_size;
          e_q    <= equal_size;
          maxl_q <= max_lower;
          minl_q <= min_larger;
        end
        S_DECIDE: begin
          lo_q <= new_lo;
          hi_q <= new_hi;
          if (!k_lt_l && k_lt_le) median_q <= pivot_q;
          else if (collapse)      median_q <= new_lo;
          else                    pivot_q  <= mid;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    busy         = (state_q != S_IDLE);
    fb_sending   = (state_q != S_FILL);
    replay_req   = (state_q == S_ISSUE);
    median_valid = (state_q == S_DONE);
    pivot        = pivot_q;
    median       = median_q;
    pass_count   = pass_q;
    state_dbg    = state_q;
  end

endmodule

// File: tb/tb_median_select_ctrl.sv
// tb_median_select_ctrl: drives median_select_ctrl with directed and random
// windows, emulating fill_buffers, and compares each median with a sorted-window
// reference.
module tb_median_select_ctrl;

  localparam int BS = 32;
  localparam int BW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] win_size = '0;
  logic          fill_done = 1'b0;
  logic [BW-1:0] lower_size = '0;
  logic [BW-1:0] equal_size = '0;
  logic [7:0]    max_lower = 8'd0;
  logic [7:0]    min_larger = 8'd0;
  logic          median_ready = 1'b0;
  logic          busy, fb_sending, replay_req, median_valid;
  logic [7:0]    pivot, median;
  logic [3:0]    pass_count;
  logic [2:0]    state_dbg;

  median_select_ctrl #(.BUFF_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_size(win_size),
    .busy(busy), .pivot(pivot), .fb_sending(fb_sending), .replay_req(replay_req),
    .fill_done(fill_done), .lower_size(lower_size), .equal_size(equal_size),
    .max_lower(max_lower), .min_larger(min_larger), .median(median),
    .median_valid(median_valid), .median_ready(median_ready),
    .pass_count(pass_count), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int replay_total = 0;
  logic [7:0] win_pix [BS];
  int win_n = 0;
  logic [31:0] exp_q [$];

  always @(posedge clk) if (replay_req) replay_total <= replay_total + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: sort the window and pick the lower median
  function automatic int ref_median();
    int q[$];
    for (int i = 0; i < win_n; i++) q.push_back(int'(win_pix[i]));
    q.sort();
    return q[(win_n - 1) / 2];
  endfunction

  // fill_buffers stand-in: classify the window against pivot p
  task automatic fill_respond(input logic [7:0] p);
    int l = 0, e = 0, ml = 0, mn = 255;
    for (int i = 0; i < win_n; i++) begin
      if (win_pix[i] < p) begin l++; if (int'(win_pix[i]) > ml) ml = int'(win_pix[i]); end
      else if (win_pix[i] == p) e++;
      else if (int'(win_pix[i]) < mn) mn = int'(win_pix[i]);
    end
    lower_size = BW'(l);
    equal_size = BW'(e);
    max_lower  = 8'(ml);
    min_larger = 8'(mn);
    fill_done  = 1'b1;
  endtask

  task automatic set9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    win_n = 9;
    win_pix[0] = 8'(a0); win_pix[1] = 8'(a1); win_pix[2] = 8'(a2);
    win_pix[3] = 8'(a3); win_pix[4] = 8'(a4); win_pix[5] = 8'(a5);
    win_pix[6] = 8'(a6); win_pix[7] = 8'(a7); win_pix[8] = 8'(a8);
  endtask

  // Driver: run one window end to end, optionally with backpressure and a
  // stray start during FILL
  task automatic run_window(input bit bp, input bit poke_start);
    int passes = 0;
    int guard;
    int r0;
    bit done = 0;
    logic [7:0] pv, m_hold;
    exp_q.push_back(32'(ref_median()));
    r0 = replay_total;
    @(negedge clk);
    win_size = BW'(win_n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    while (!done) begin
      guard = 0;
      while (!replay_req && !median_valid && guard < 8) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 8) begin
        check_eq("wait_timeout", 32'd0, 32'd1);
        break;
      end
      if (median_valid) begin
        done = 1;
      end else begin
        passes++;
        pv = pivot;
        if (passes > 12) begin
          check_eq("pass_overrun", 32'(passes), 32'd9);
          break;
        end
        @(negedge clk);
        if (poke_start && passes == 1) begin
          start = 1'b1;
          win_size = BW'(3);
          @(negedge clk);
          start = 1'b0;
          win_size = BW'(win_n);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check_eq("fb_sending_fill", 32'(fb_sending), 32'd0);
        check_eq("pivot_stable", 32'(pivot), 32'(pv));
        fill_respond(pivot);
        @(negedge clk);
        fill_done = 1'b0;
      end
    end
    if (done) begin
      check_eq("median", 32'(median), exp_q.pop_front());
      check_eq("pass_count", 32'(pass_count), 32'(passes));
      check_eq("replay_pulses", 32'(replay_total - r0), 32'(pass_count));
      check_eq("passes_le_9", 32'(passes <= 9), 32'd1);
      if (bp) begin
        m_hold = median;
        r0 = replay_total;
        repeat (10) @(negedge clk);
        check_eq("bp_valid_held", 32'(median_valid), 32'd1);
        check_eq("bp_median_held", 32'(median), 32'(m_hold));
        check_eq("bp_no_replay", 32'(replay_total), 32'(r0));
      end
      median_ready = 1'b1;
      @(negedge clk);
      median_ready = 1'b0;
      check_eq("valid_drop", 32'(median_valid), 32'd0);
      check_eq("idle_after_hs", 32'(busy), 32'd0);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_pivot"}, 32'(pivot), 32'd0);
    check_eq({tag, "_fb_sending"}, 32'(fb_sending), 32'd1);
    check_eq({tag, "_replay"}, 32'(replay_req), 32'd0);
    check_eq({tag, "_median"}, 32'(median), 32'd0);
    check_eq({tag, "_valid"}, 32'(median_valid), 32'd0);
    check_eq({tag, "_pass_count"}, 32'(pass_count), 32'd0);
  endtask

  task automatic try_illegal(input int sz);
    int r0 = replay_total;
    @(negedge clk);
    win_size = BW'(sz);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("illegal_busy", 32'(busy), 32'd0);
    check_eq("illegal_replay", 32'(replay_total), 32'(r0));
  endtask

  initial begin
    int guard;
    // reset
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // odd window
    set9(7, 3, 9, 1, 5, 8, 2, 6, 4);
    run_window(0, 0);
    // even window, lower median
    win_n = 4;
    win_pix[0] = 8'd40; win_pix[1] = 8'd10; win_pix[2] = 8'd30; win_pix[3] = 8'd20;
    run_window(0, 0);
    // all duplicates
    set9(100, 100, 100, 100, 100, 100, 100, 100, 100);
    run_window(0, 0);
    // single pixel
    win_n = 1;
    win_pix[0] = 8'd200;
    run_window(0, 0);
    // illegal sizes
    try_illegal(0);
    try_illegal(33);
    // stray start during FILL, then backpressure
    set9(50, 20, 90, 10, 70, 30, 80, 40, 60);
    run_window(0, 1);
    set9(12, 250, 3, 128, 127, 126, 0, 255, 64);
    run_window(1, 0);

    // reset while waiting in FILL
    set9(9, 8, 7, 6, 5, 4, 3, 2, 1);
    @(negedge clk);
    win_size = BW'(9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!replay_req && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rst_fill_reached", 32'(replay_req), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_window(0, 0);

    // random windows
    for (int w = 0; w < 24; w++) begin
      bit narrow = ($urandom_range(0, 1) == 1);
      win_n = $urandom_range(1, BS);
      for (int i = 0; i < win_n; i++)
        win_pix[i] = narrow ? 8'($urandom_range(100, 104)) : 8'($urandom_range(0, 255));
      run_window($urandom_range(0, 3) == 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/median_select_ctrl.md
# median_select_ctrl

Sequencing controller for the partition-based median filter. It drives `fill_buffers` through repeated classification passes over one pixel window, using value-domain bisection on the pivot, and stops when the rank-k element (the median) is isolated. It sits between the window source (which replays the window on request) and the downstream pixel sink, which receives one median per window.

## Interface

- `BUFF_SIZE`, 32: maximum window size in pixels; must match `fill_buffers`.
- `BUFF_SIZE_BIT`, `$clog2(BUFF_SIZE)+1`: width of size and count fields.

Ports:

- `clk` input 1: clock. One clock domain.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `start` input 1: begin a median search; accepted only in IDLE.
- `win_size` input BUFF_SIZE_BIT: window size N, sampled when `start` is accepted.
- `busy` output 1: high in every state except IDLE.
- `pivot` output 8: registered pivot to `fill_buffers`; stable for a whole pass.
- `fb_sending` output 1: drives `fill_buffers.sending`; low only in FILL, which stalls the fill block outside a pass.
- `replay_req` output 1: one-cycle pulse asking the window source to re-stream the N pixels.
- `fill_done` input 1: from `fill_buffers`.
- `lower_size`, `equal_size` input BUFF_SIZE_BIT each: from `fill_buffers`.
- `max_lower`, `min_larger` input 8 each: from `fill_buffers`.
- `median` output 8: result. Valid while `median_valid` is high.
- `median_valid` output 1: result handshake, valid side.
- `median_ready` input 1: result handshake, ready side.
- `pass_count` output 4: passes run for the current or last window; saturates at 15.

## Operation

- States: IDLE, LOAD, ISSUE, FILL, DECIDE, DONE.
- **IDLE**
  - `start`=1 with 1 ≤ `win_size` ≤ BUFF_SIZE: latch N, go to LOAD.
  - `start` with `win_size` 0 or > BUFF_SIZE: ignore, stay in IDLE.
- **LOAD**
  - Set k = (N-1)>>1. Even N gives the lower median.
  - Set lo=0, hi=255, pivot = (lo+hi)>>1 = 127, pass_count=0.
  - Go to ISSUE.
- **ISSUE**
  - Pulse `replay_req` for one cycle.
  - Increment pass_count (saturating).
  - Go to FILL.
- **FILL**
  - `fb_sending`=0. Wait for `fill_done`=1.
  - In that same cycle, sample L=`lower_size`, E=`equal_size`, `max_lower` and `min_larger` into registers, because `fill_buffers` clears them on the next edge.
  - Go to DECIDE.
- **DECIDE** (one cycle; L+E computed at BUFF_SIZE_BIT+1 bits):
  - k < L: hi = sampled `max_lower`.
  - else k < L+E: median = pivot; go to DONE.
  - else: lo = sampled `min_larger`.
  - If not done and the new lo == new hi: median = lo; go to DONE.
  - Otherwise: pivot = (lo+hi)>>1 using a 9-bit sum; go to ISSUE.
- **DONE**
  - `median_valid`=1; `median` held stable.
  - On `median_valid` && `median_ready`: go to IDLE. `median_valid` drops the next cycle.
- Convergence: each non-terminal pass strictly shrinks [lo,hi], so at most 9 passes are needed. The pivot need not be a pixel value; E=0 is legal.
- `start` asserted outside IDLE is ignored.

## Timing

- Reset values:
  - State IDLE.
  - `busy`=0, `pivot`=0, `fb_sending`=1, `replay_req`=0.
  - `median`=0, `median_valid`=0, `pass_count`=0.
  - Internal lo=0, hi=255.
- Reset mid-operation (any state) returns immediately to the reset values. No result is emitted for that window.
- `start` accepted at edge t:
  - LOAD at t+1.
  - `replay_req` high during the ISSUE cycle, t+2.
  - FILL from t+3.
- Per pass, excluding FILL wait: 2 cycles (ISSUE, DECIDE).
- `pivot` changes only on the LOAD→ISSUE or DECIDE→ISSUE transition, never during FILL.
- `median_valid` rises on the edge leaving DECIDE.
- Back-to-back windows: `start` may be accepted the cycle after the DONE handshake.

## Test plan

- **Odd window:** N=9, pixels {7,3,9,1,5,8,2,6,4} -> `median`=5; `pass_count` ≤ 9; `replay_req` pulses equal `pass_count`.
- **Even window and duplicates:**
  - N=4, {40,10,30,20} -> `median`=20 (lower median).
  - N=9, all 100 -> `median`=100.
- **Single-pixel window:** N=1, {200} -> `median`=200.
- **Illegal sizes:**
  - `win_size`=0 or 33 with `start` -> stays IDLE, `busy`=0, no `replay_req`.
  - `start` pulsed during FILL -> ignored.
- **Backpressure:** `median_ready` low for 10 cycles after valid -> `median_valid` and `median` stay stable, no new `replay_req`; release -> IDLE the next cycle.
- **Reset mid-FILL:** assert `rst_n`=0 while waiting in FILL -> all outputs at reset values. A subsequent N=9 window still returns the correct median.
